// File: rtl/spell_loader_pkg.sv
// Shared encodings for the debug-port spell loader: host op codes,
// core register selects and the controller state encoding.
package spell_loader_pkg;

  typedef enum logic [1:0] {
    OP_LOAD     = 2'd0,
    OP_DUMP     = 2'd1,
    OP_RUN      = 2'd2,
    OP_RESERVED = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    SEL_PC        = 2'd0,
    SEL_SP        = 2'd1,
    SEL_EXEC      = 2'd2,
    SEL_STACK_TOP = 2'd3
  } sel_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SHIFT   = 3'd1,
    ST_LOAD    = 3'd2,
    ST_DUMP    = 3'd3,
    ST_CAPTURE = 3'd4,
    ST_RUN     = 3'd5
  } state_e;

  // Index of the last serial bit of a byte; reaching it closes a shift/sample phase.
  localparam logic [2:0] LAST_BIT = 3'd7;

endpackage

// File: rtl/spell_loader.sv
// Host-command front end for a core's serial debug port. LOAD shifts a byte
// MSB first and strobes dbg_load, DUMP strobes dbg_dump and captures the byte
// the core shifts back after DUMP_LAT cycles, RUN pulses dbg_run with a step bit.
module spell_loader
  import spell_loader_pkg::*;
#(
  parameter int DUMP_LAT = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [1:0] cmd_sel,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       dbg_shift_out,
  output logic       dbg_load,
  output logic       dbg_dump,
  output logic       dbg_run,
  output logic       dbg_step,
  output logic [1:0] dbg_sel,
  input  logic       dbg_shift_in
);

  // The DUMP cycle itself covers one cycle of the core latency; CAPTURE idles for the rest.
  localparam int                WAIT_W    = (DUMP_LAT > 1) ? $clog2(DUMP_LAT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(DUMP_LAT - 1);

  state_e            r_state;
  logic [7:0]        r_shift;
  logic [2:0]        r_bit_cnt;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic              r_shift_out;
  logic              r_load;
  logic              r_dump;
  logic              r_run;
  logic              r_step;
  logic [1:0]        r_sel;
  logic              r_rsp_valid;
  logic [7:0]        r_rsp_data;

  logic              w_accept;
  logic [7:0]        w_capture_byte;

  // cmd_ready is a pure function of state, so a held cmd_valid simply waits for IDLE.
  assign cmd_ready      = (r_state == ST_IDLE);
  assign w_accept       = cmd_valid && cmd_ready;
  assign w_capture_byte = {r_shift[6:0], dbg_shift_in};

  assign dbg_shift_out = r_shift_out;
  assign dbg_load      = r_load;
  assign dbg_dump      = r_dump;
  assign dbg_run       = r_run;
  assign dbg_step      = r_step;
  assign dbg_sel       = r_sel;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_data      = r_rsp_data;

  // Command sequencer: state, shared shift/capture register, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_wait_cnt  <= '0;
      r_shift_out <= 1'b0;
      r_load      <= 1'b0;
      r_dump      <= 1'b0;
      r_run       <= 1'b0;
      r_step      <= 1'b0;
      r_sel       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      // Strobes are single-cycle unless a state re-asserts them below.
      r_load      <= 1'b0;
      r_dump      <= 1'b0;
      r_rsp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_sel     <= cmd_sel;
            r_bit_cnt <= '0;
            case (op_e'(cmd_op))
              OP_LOAD: begin
                r_state     <= ST_SHIFT;
                r_shift     <= cmd_data;
                r_shift_out <= cmd_data[7];
              end
              OP_DUMP: begin
                r_state <= ST_DUMP;
                r_dump  <= 1'b1;
              end
              OP_RUN: begin
                r_state <= ST_RUN;
                r_run   <= 1'b1;
                r_step  <= cmd_data[0];
              end
              default: r_state <= ST_IDLE;
            endcase
          end
        end
        ST_SHIFT: begin
          if (r_bit_cnt == LAST_BIT) begin
            r_state     <= ST_LOAD;
            r_load      <= 1'b1;
            r_shift_out <= 1'b0;
            r_bit_cnt   <= '0;
          end else begin
            r_bit_cnt   <= r_bit_cnt + 3'd1;
            r_shift     <= {r_shift[6:0], 1'b0};
            r_shift_out <= r_shift[6];
          end
        end
        ST_LOAD: begin
          r_state <= ST_IDLE;
        end
        ST_DUMP: begin
          r_state    <= ST_CAPTURE;
          r_wait_cnt <= WAIT_INIT;
        end
        ST_CAPTURE: begin
          if (r_wait_cnt != '0) begin
            r_wait_cnt <= r_wait_cnt - WAIT_W'(1);
          end else begin
            r_shift <= w_capture_byte;
            if (r_bit_cnt == LAST_BIT) begin
              r_state     <= ST_IDLE;
              r_bit_cnt   <= '0;
              r_rsp_data  <= w_capture_byte;
              r_rsp_valid <= 1'b1;
            end else begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end
          end
        end
        ST_RUN: begin
          // First RUN cycle drops dbg_run; the second holds it low and leaves.
          if (r_bit_cnt == 3'd0) begin
            r_run     <= 1'b0;
            r_bit_cnt <= 3'd1;
          end else begin
            r_step    <= 1'b0;
            r_bit_cnt <= '0;
            r_state   <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spell_loader.sv
// Bench for spell_loader: a behavioural core (register file fed by the serial
// load path, answering dumps after DUMP_LAT cycles), a table of directed
// commands, hand-built back-to-back and reset-abort sequences, and random commands.
module tb_spell_loader;
  import spell_loader_pkg::*;

  localparam int DUMP_LAT = 2;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [1:0] cmd_sel;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       dbg_shift_out;
  logic       dbg_load;
  logic       dbg_dump;
  logic       dbg_run;
  logic       dbg_step;
  logic [1:0] dbg_sel;
  logic       dbg_shift_in;

  spell_loader #(.DUMP_LAT(DUMP_LAT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_sel      (cmd_sel),
    .cmd_data     (cmd_data),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .dbg_shift_out(dbg_shift_out),
    .dbg_load     (dbg_load),
    .dbg_dump     (dbg_dump),
    .dbg_run      (dbg_run),
    .dbg_step     (dbg_step),
    .dbg_sel      (dbg_sel),
    .dbg_shift_in (dbg_shift_in)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // {cmd_ready, dbg_load, dbg_dump, dbg_run, dbg_shift_out, rsp_valid}
  function automatic logic [5:0] status();
    return {cmd_ready, dbg_load, dbg_dump, dbg_run, dbg_shift_out, rsp_valid};
  endfunction

  // Negedge monitor: cycle index, acceptances and strobe counts.
  int ncyc = 0;
  int load_count = 0;
  int rsp_count = 0;
  int acc_q[$];
  always @(negedge clk) begin
    ncyc++;
    if (cmd_valid && cmd_ready && rst_n) acc_q.push_back(ncyc);
    if (dbg_load) load_count++;
    if (rsp_valid) rsp_count++;
  end

  // Behavioural core: registers written from the last 8 serial bits on dbg_load,
  // dump answered MSB first starting DUMP_LAT cycles after the strobe cycle.
  logic [7:0] core_regs [4];
  logic [7:0] core_hist;
  bit         core_q[$];
  initial begin : core_model
    bit nxt;
    core_regs[0] = 8'hC1;
    core_regs[1] = 8'h13;
    core_regs[2] = 8'h42;
    core_regs[3] = 8'h5E;
    core_hist    = 8'h00;
    dbg_shift_in = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        core_q.delete();
      end else begin
        if (dbg_load) core_regs[dbg_sel] = core_hist;
        core_hist = {core_hist[6:0], dbg_shift_out};
        if (dbg_dump) begin
          for (int i = 0; i < DUMP_LAT - 1; i++) core_q.push_back(1'($urandom_range(0, 1)));
          for (int i = 7; i >= 0; i--) core_q.push_back(core_regs[dbg_sel][i]);
        end
      end
      nxt = (core_q.size() > 0) ? core_q.pop_front() : 1'($urandom_range(0, 1));
      @(posedge clk);
      #1 dbg_shift_in = nxt;
    end
  end

  // Reference view of the core registers and of the last dump result.
  logic [7:0] exp_regs [4];
  logic [7:0] last_rsp;

  // Offer a command and wait (bounded) for the accepting edge; returns 1 ns after it.
  task automatic start_cmd(input logic [1:0] op, input logic [1:0] sel, input logic [7:0] data,
                           input string tag, output bit ok);
    int waitc;
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_sel   = sel;
    cmd_data  = data;
    waitc = 0;
    @(negedge clk);
    while (!cmd_ready && waitc < 40) begin
      @(negedge clk);
      waitc++;
    end
    ok = cmd_ready;
    chk({tag, " accept"}, 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = 2'($urandom_range(0, 3));
    cmd_sel   = 2'($urandom_range(0, 3));
    cmd_data  = 8'($urandom_range(0, 255));
  endtask

  // Issue one command and check every cycle of its occupancy against the waveform rules.
  task automatic do_cmd(input logic [1:0] op, input logic [1:0] sel, input logic [7:0] data,
                        input logic [7:0] exp_rsp, input string tag);
    int         len;
    bit         ok;
    logic [5:0] e;
    start_cmd(op, sel, data, tag, ok);
    if (!ok) return;
    case (op)
      OP_LOAD: len = 10;
      OP_DUMP: len = DUMP_LAT + 9;
      OP_RUN:  len = 3;
      default: len = 1;
    endcase
    for (int c = 1; c <= len; c++) begin
      @(negedge clk);
      e = 6'b0;
      case (op)
        OP_LOAD: begin
          if (c <= 8)       e[1] = data[8 - c];
          else if (c == 9)  e[4] = 1'b1;
          else              e[5] = 1'b1;
        end
        OP_DUMP: begin
          if (c == 1)        e[3] = 1'b1;
          else if (c == len) begin e[5] = 1'b1; e[0] = 1'b1; end
        end
        OP_RUN: begin
          if (c == 1)      e[2] = 1'b1;
          else if (c == 3) e[5] = 1'b1;
        end
        default: e[5] = 1'b1;
      endcase
      chk($sformatf("%s c%0d status", tag, c), 32'(status()), 32'(e));
      if (op != OP_RESERVED) chk($sformatf("%s c%0d dbg_sel", tag, c), 32'(dbg_sel), 32'(sel));
      if (op == OP_RUN && c <= 2) chk($sformatf("%s c%0d dbg_step", tag, c), 32'(dbg_step), 32'(data[0]));
      if (op == OP_DUMP && c == len) begin
        chk($sformatf("%s rsp_data", tag), 32'(rsp_data), 32'(exp_rsp));
        last_rsp = exp_rsp;
      end
    end
    chk({tag, " rsp_data hold"}, 32'(rsp_data), 32'(last_rsp));
  endtask

  typedef struct {
    logic [1:0] op;
    logic [1:0] sel;
    logic [7:0] data;
    logic [7:0] exp_rsp;
  } vec_t;

  vec_t vecs [11];

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    bit ok;
    int load_base;
    int rsp_base;
    int gap;

    vecs[0]  = '{OP_LOAD,     SEL_PC,        8'hA5, 8'h00};
    vecs[1]  = '{OP_DUMP,     SEL_SP,        8'h00, 8'h13};
    vecs[2]  = '{OP_RUN,      SEL_EXEC,      8'h01, 8'h00};
    vecs[3]  = '{OP_RESERVED, SEL_PC,        8'hFF, 8'h00};
    vecs[4]  = '{OP_DUMP,     SEL_PC,        8'h00, 8'hA5};
    vecs[5]  = '{OP_LOAD,     SEL_EXEC,      8'h3C, 8'h00};
    vecs[6]  = '{OP_DUMP,     SEL_EXEC,      8'hFF, 8'h3C};
    vecs[7]  = '{OP_RUN,      SEL_SP,        8'hFE, 8'h00};
    vecs[8]  = '{OP_LOAD,     SEL_SP,        8'h80, 8'h00};
    vecs[9]  = '{OP_DUMP,     SEL_SP,        8'h00, 8'h80};
    vecs[10] = '{OP_DUMP,     SEL_STACK_TOP, 8'h00, 8'h5E};

    exp_regs[0] = 8'hC1;
    exp_regs[1] = 8'h13;
    exp_regs[2] = 8'h42;
    exp_regs[3] = 8'h5E;
    last_rsp    = 8'h00;

    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    cmd_sel   = 2'd0;
    cmd_data  = 8'd0;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("reset strobes", 32'(status() & 6'b011111), 32'd0);
    chk("reset dbg_sel", 32'(dbg_sel), 32'd0);
    chk("reset dbg_step", 32'(dbg_step), 32'd0);
    chk("reset rsp_data", 32'(rsp_data), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("post-reset cmd_ready", 32'(cmd_ready), 32'd1);

    // Directed table.
    for (int i = 0; i < 11; i++) begin
      do_cmd(vecs[i].op, vecs[i].sel, vecs[i].data, vecs[i].exp_rsp, $sformatf("vec%0d", i));
      if (vecs[i].op == OP_LOAD) exp_regs[vecs[i].sel] = vecs[i].data;
    end

    // Back-to-back LOADs with cmd_valid held high throughout.
    acc_q.delete();
    load_base = load_count;
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_op    = OP_LOAD;
    cmd_sel   = SEL_STACK_TOP;
    cmd_data  = 8'h11;
    gap = 0;
    @(negedge clk);
    while (!cmd_ready && gap < 40) begin @(negedge clk); gap++; end
    @(posedge clk);
    #1 cmd_data = 8'h22;
    gap = 0;
    @(negedge clk);
    while (!cmd_ready && gap < 40) begin @(negedge clk); gap++; end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (11) @(negedge clk);
    chk("b2b accept gap", (acc_q.size() == 2) ? 32'(acc_q[1] - acc_q[0]) : 32'hFFFF_FFFF, 32'd10);
    chk("b2b load pulses", 32'(load_count - load_base), 32'd2);
    exp_regs[3] = 8'h22;
    do_cmd(OP_DUMP, SEL_STACK_TOP, 8'h00, exp_regs[3], "b2b dump");

    // Reset while shifting bit 4 of a LOAD: no load may follow.
    start_cmd(OP_LOAD, SEL_EXEC, 8'hF0, "rst-shift", ok);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst-shift cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst-shift strobes", 32'(status() & 6'b011111), 32'd0);
    chk("rst-shift dbg_sel", 32'(dbg_sel), 32'd0);
    load_base = load_count;
    last_rsp  = 8'h00;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (14) @(negedge clk);
    chk("rst-shift no dbg_load", 32'(load_count - load_base), 32'd0);
    do_cmd(OP_DUMP, SEL_EXEC, 8'h00, exp_regs[2], "rst-shift dump");

    // Reset while capturing a DUMP: no response may follow.
    start_cmd(OP_DUMP, SEL_SP, 8'h00, "rst-cap", ok);
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    rsp_base = rsp_count;
    last_rsp = 8'h00;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("rst-cap no rsp_valid", 32'(rsp_count - rsp_base), 32'd0);
    chk("rst-cap rsp_data", 32'(rsp_data), 32'd0);

    // Random commands against the reference register file.
    for (int i = 0; i < 40; i++) begin
      logic [1:0] op;
      logic [1:0] sel;
      logic [7:0] data;
      op   = 2'($urandom_range(0, 3));
      sel  = 2'($urandom_range(0, 3));
      data = 8'($urandom_range(0, 255));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      do_cmd(op, sel, data, exp_regs[sel], $sformatf("rnd%0d", i));
      if (op == OP_LOAD) exp_regs[sel] = data;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spell_loader.md
SPELL_LOADER -- requirements
Module: spell_loader

Interface
REQ-001 SHALL have parameter DUMP_LAT, default 2, meaning clock cycles from the dump strobe to the first valid serial bit on dbg_shift_in.
REQ-002 SHALL have ports: clk in 1 (clock); rst_n in 1 (reset, asynchronous, active-low).
REQ-003 SHALL have ports: cmd_valid in 1 (host command offered); cmd_ready out 1 (command accepted this cycle); cmd_op in 2 (0=LOAD, 1=DUMP, 2=RUN, 3=RESERVED); cmd_sel in 2 (target register: 0=PC, 1=SP, 2=EXEC, 3=STACK_TOP); cmd_data in 8 (LOAD byte; RUN uses bit 0 as step).
REQ-004 SHALL have ports: rsp_valid out 1 (one-cycle pulse, dump result ready); rsp_data out 8 (dump result byte).
REQ-005 SHALL have ports toward the core debug port: dbg_shift_out out 1 (serial bit into the core); dbg_load out 1; dbg_dump out 1; dbg_run out 1; dbg_step out 1; dbg_sel out 2; dbg_shift_in in 1 (core serial output).

Function
REQ-006 SHALL implement states IDLE, SHIFT, LOAD, DUMP, CAPTURE, RUN.
REQ-007 SHALL assert cmd_ready only in IDLE; a command SHALL be accepted on a rising edge where cmd_valid and cmd_ready are both high; cmd_op, cmd_sel and cmd_data SHALL be latched at that edge.
REQ-008 SHALL transition IDLE→SHIFT on an accepted LOAD, IDLE→DUMP on DUMP, and IDLE→RUN on RUN; RESERVED SHALL be accepted and discarded, with the block staying in IDLE.
REQ-009 SHIFT SHALL last exactly 8 cycles, driving dbg_shift_out with the latched byte MSB first (bit 7 in the first SHIFT cycle), then transition to LOAD.
REQ-010 LOAD SHALL last 1 cycle with dbg_load=1 and dbg_sel=latched sel, then transition to IDLE; total LOAD command occupancy SHALL be 9 cycles.
REQ-011 DUMP SHALL last 1 cycle with dbg_dump=1 and dbg_sel=latched sel, then transition to CAPTURE.
REQ-012 CAPTURE SHALL wait DUMP_LAT-1 cycles, then sample dbg_shift_in on 8 consecutive edges MSB first into an 8-bit register; after the 8th sample it SHALL pulse rsp_valid for 1 cycle, with rsp_data holding the byte, and return to IDLE.
REQ-013 rsp_data SHALL hold its last value until the next dump completes.
REQ-014 RUN SHALL last 2 cycles: dbg_run=1 in the first cycle and dbg_run=0 in the second, producing a rising edge followed by a guaranteed low; dbg_step SHALL equal the latched data bit 0 for both cycles; the block then returns to IDLE.
REQ-015 Outside the states that own them, dbg_load, dbg_dump and dbg_run SHALL be 0; dbg_shift_out SHALL be 0 outside SHIFT.
REQ-016 dbg_sel SHALL hold the latched sel from acceptance until the next accepted command.
REQ-017 All outputs SHALL be registered; there SHALL be no combinational path from any input to any output except cmd_ready, which depends on state only.
REQ-018 The 3-bit bit counter SHALL count 0..7 and SHALL never wrap silently; a count of 7 SHALL end SHIFT or the sampling phase of CAPTURE.
REQ-019 cmd_valid while busy SHALL be ignored without loss: the command stays pending until cmd_ready is high.

Reset
REQ-020 On rst_n low, the block SHALL asynchronously enter IDLE with all outputs 0, except cmd_ready=1 after reset release; rsp_data=0, counters=0, latches=0.
REQ-021 Reset asserted mid-command SHALL abort the command; no rsp_valid pulse and no dbg_load/dbg_run pulse SHALL be emitted afterwards.

Structure
REQ-022 A shared package SHALL hold the op codes (LOAD/DUMP/RUN/RESERVED), the register-select codes (PC/SP/EXEC/STACK_TOP), and the state encoding.
REQ-023 The block SHALL be a single module with no sub-module; the shift/capture datapath is one 8-bit register plus a 3-bit counter.

Verification
REQ-024 LOAD sel=PC data=0xA5 → dbg_shift_out shows 1,0,1,0,0,1,0,1 over 8 cycles; dbg_load=1 on cycle 9 with dbg_sel=0; cmd_ready high again on cycle 10.
REQ-025 DUMP sel=SP against a core model returning 0x13 with 2-cycle latency → rsp_valid pulses once, rsp_data=0x13, 11 cycles after acceptance.
REQ-026 RUN data=0x01 → dbg_run high for 1 cycle then low, dbg_step=1 for both cycles, IDLE on cycle 3.
REQ-027 Back-to-back LOAD sel=STACK_TOP 0x11 then 0x22 with cmd_valid held → second accepted exactly 10 cycles after the first; two dbg_load pulses.
REQ-028 rst_n low during SHIFT bit 4 → immediate IDLE, no dbg_load pulse; rst_n low during CAPTURE → no rsp_valid pulse.
REQ-029 RESERVED op → accepted in 1 cycle, no dbg_* activity, cmd_ready stays high.
